psram_port_arb: RTL and testbench

PSRAM_PORT_ARB -- requirements
Module: psram_port_arb

---
 rtl/psram_port_arb_if.sv | 52 +++++
 rtl/psram_port_arb.sv | 144 ++++++++++++++
 tb/tb_psram_port_arb.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_port_arb_if.sv
// Bundle of the arbiter's bus signals: two requester ports, the PSRAM sequencer
// side, and status/error lines. "slave" is the arbiter's view, "master" the
// environment's view (requesters plus sequencer).
interface psram_port_arb_if;
  logic        req0_valid;
  logic        req0_write;
  logic [23:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        req0_ready;
  logic [31:0] req0_rdata;

  logic        req1_valid;
  logic        req1_write;
  logic [23:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        req1_ready;
  logic [31:0] req1_rdata;

  logic        mem_valid;
  logic        mem_write;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        busy;
  logic        owner;
  logic        err_timeout;
  logic        err_clear;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, req0_rdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, req1_rdata,
    output mem_valid, mem_write, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output busy, owner, err_timeout,
    input  err_clear
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, req0_rdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, req1_rdata,
    input  mem_valid, mem_write, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  busy, owner, err_timeout,
    output err_clear
  );
endinterface

// File: rtl/psram_port_arb.sv
// Two-port PSRAM arbiter: port 0 (SPI flash emulation) has priority, port 1
// (CPU iomem) is guaranteed a grant after STARVE_LIMIT consecutive port-0 grants.
// One transaction in flight at a time: IDLE -> WAIT -> RESP -> IDLE.
// Optional watchdog enabled by defining PSRAM_ARB_TIMEOUT_EN; without it a WAIT
// lasts until the sequencer answers and err_timeout stays 0.
module psram_port_arb #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            resetn,
  psram_port_arb_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_t        r_state;
  logic [SW-1:0] r_starve_cnt;
  logic          r_owner;
  logic          r_write;
  logic [23:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_mem_valid;
  logic          r_busy;
  logic          r_ready0;
  logic          r_ready1;
  logic [31:0]   r_rdata0;
  logic [31:0]   r_rdata1;
  logic          r_err;

  logic          w_starved;
  logic          w_pick1;
  logic          w_timeout;

  // Port 1 wins only if port 0 is idle or port 1 has waited out the limit.
  assign w_starved = (r_starve_cnt == SW'(STARVE_LIMIT));
  assign w_pick1   = bus.req1_valid && (!bus.req0_valid || w_starved);

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wait_cnt;
  // Fires in the WAIT cycle that completes TIMEOUT_CYCLES without mem_ready.
  assign w_timeout = (r_state == S_WAIT) && !bus.mem_ready &&
                     (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = bus.err_clear | (TIMEOUT_CYCLES == 0);
`endif

  // Arbitration FSM with all bus outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_owner      <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_ready0     <= 1'b0;
      r_ready1     <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_err        <= 1'b0;
`ifdef PSRAM_ARB_TIMEOUT_EN
      r_wait_cnt   <= '0;
`endif
    end else begin
      r_ready0 <= 1'b0;
      r_ready1 <= 1'b0;
      // Clear first so a timeout in the same cycle (assigned later) wins.
      if (bus.err_clear) r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req0_valid || bus.req1_valid) begin
            r_owner     <= w_pick1;
            r_write     <= w_pick1 ? bus.req1_write : bus.req0_write;
            r_addr      <= w_pick1 ? bus.req1_addr  : bus.req0_addr;
            r_wdata     <= w_pick1 ? bus.req1_wdata : bus.req0_wdata;
            r_mem_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_WAIT;
`ifdef PSRAM_ARB_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
            // Starvation count tracks port-0 wins while port 1 is waiting.
            if (w_pick1 || !bus.req1_valid) r_starve_cnt <= '0;
            else if (!w_starved)            r_starve_cnt <= r_starve_cnt + SW'(1);
          end
        end
        S_WAIT: begin
          if (bus.mem_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= S_RESP;
            if (r_owner) r_ready1 <= 1'b1;
            else         r_ready0 <= 1'b1;
            if (!r_write) begin
              if (r_owner) r_rdata1 <= bus.mem_rdata;
              else         r_rdata0 <= bus.mem_rdata;
            end
          end else if (w_timeout) begin
            r_mem_valid <= 1'b0;
            r_state     <= S_RESP;
            r_err       <= 1'b1;
            if (r_owner) begin
              r_ready1 <= 1'b1;
              r_rdata1 <= 32'hFFFF_FFFF;
            end else begin
              r_ready0 <= 1'b1;
              r_rdata0 <= 32'hFFFF_FFFF;
            end
          end
`ifdef PSRAM_ARB_TIMEOUT_EN
          else begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
          end
`endif
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_valid   = r_mem_valid;
  assign bus.mem_write   = r_write;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wdata   = r_wdata;
  assign bus.req0_ready  = r_ready0;
  assign bus.req1_ready  = r_ready1;
  assign bus.req0_rdata  = r_rdata0;
  assign bus.req1_rdata  = r_rdata1;
  assign bus.busy        = r_busy;
  assign bus.owner       = r_owner;
  assign bus.err_timeout = r_err;

endmodule

// File: tb/tb_psram_port_arb.sv
// Directed bench for psram_port_arb: reset, starvation-limited arbitration,
// single-port write latency, long sequencer wait, watchdog (PSRAM_ARB_TIMEOUT_EN)
// or unbounded wait, spurious mem_ready, and reset in the middle of a WAIT.
module tb_psram_port_arb;
  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;
  bit   auto_mem;
  logic [31:0] exp_rd0;
  logic [31:0] exp_rd1;

  psram_port_arb_if bus();

  psram_port_arb #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge; optionally act as a sequencer that
  // answers in the first WAIT cycle with data derived from the address.
  task automatic tick();
    @(negedge clk);
    if (auto_mem) begin
      bus.mem_ready = bus.mem_valid;
      bus.mem_rdata = {8'hA5, bus.mem_addr};
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    n_cmp++;
    if ({bus.mem_valid, bus.busy, bus.owner, bus.req0_ready, bus.req1_ready, bus.err_timeout} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags got=%b want=000000", {bus.mem_valid, bus.busy, bus.owner, bus.req0_ready, bus.req1_ready, bus.err_timeout});
    end
    n_cmp++;
    if ({bus.req0_rdata, bus.req1_rdata, bus.mem_addr, bus.mem_wdata} !== 112'b0) begin
      n_err++;
      $display("FAIL reset_data got=%h want=0", {bus.req0_rdata, bus.req1_rdata, bus.mem_addr, bus.mem_wdata});
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int exp_order [12];
    int n0, n1, ng;
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1};
    n0 = 0; n1 = 0; ng = 0;
    auto_mem = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 24'h000100;
    bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 24'h100000;
    for (int cyc = 0; cyc < 200 && ng < 12; cyc++) begin
      tick();
      if (bus.req0_ready && bus.req1_ready) begin
        n_cmp++; n_err++;
        $display("FAIL b2b_dual_ready both ports ready in one cycle, want one");
      end else if (bus.req0_ready || bus.req1_ready) begin
        $display("txn %0d: port=%0d rdata0=%h rdata1=%h", ng, bus.req1_ready, bus.req0_rdata, bus.req1_rdata);
        n_cmp++;
        if (int'(bus.req1_ready) != exp_order[ng]) begin
          n_err++;
          $display("FAIL b2b_order grant %0d got port %0d want %0d", ng, bus.req1_ready, exp_order[ng]);
        end
        if (bus.req0_ready) begin
          exp_rd0 = {8'hA5, 24'h000100 + 24'(n0)};
          n_cmp++;
          if (bus.req0_rdata !== exp_rd0) begin
            n_err++;
            $display("FAIL b2b_rdata0 got=%h want=%h", bus.req0_rdata, exp_rd0);
          end
          n0++;
          if (n0 < 6) bus.req0_addr = 24'h000100 + 24'(n0);
          else        bus.req0_valid = 1'b0;
        end else begin
          exp_rd1 = {8'hA5, 24'h100000 + 24'(n1)};
          n_cmp++;
          if (bus.req1_rdata !== exp_rd1) begin
            n_err++;
            $display("FAIL b2b_rdata1 got=%h want=%h", bus.req1_rdata, exp_rd1);
          end
          n1++;
          if (n1 < 6) bus.req1_addr = 24'h100000 + 24'(n1);
          else        bus.req1_valid = 1'b0;
        end
        ng++;
      end
    end
    n_cmp++;
    if (ng != 12) begin
      n_err++;
      $display("FAIL b2b_count got=%0d want=12", ng);
    end
    auto_mem = 1'b0;
    bus.mem_ready = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_write_latency();
    // cycle 1: request presented
    bus.req1_valid = 1'b1; bus.req1_write = 1'b1;
    bus.req1_addr = 24'h001000; bus.req1_wdata = 32'hDEADBEEF;
    tick(); // cycle 2: WAIT
    n_cmp++;
    if ({bus.mem_valid, bus.mem_write, bus.busy, bus.owner} !== 4'b1111 ||
        bus.mem_addr !== 24'h001000 || bus.mem_wdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL wr_fields got v/w/b/o=%b addr=%h data=%h want 1111 001000 deadbeef",
               {bus.mem_valid, bus.mem_write, bus.busy, bus.owner}, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    tick(); // cycle 3: RESP
    bus.mem_ready = 1'b0;
    n_cmp++;
    if ({bus.req1_ready, bus.req0_ready, bus.mem_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL wr_ready_c3 got r1/r0/mv=%b want 100", {bus.req1_ready, bus.req0_ready, bus.mem_valid});
    end
    n_cmp++;
    if (bus.req1_rdata !== exp_rd1) begin
      n_err++;
      $display("FAIL wr_rdata_hold got=%h want=%h", bus.req1_rdata, exp_rd1);
    end
    $display("txn write: port=1 addr=001000 data=deadbeef");
    bus.req1_valid = 1'b0;
    tick();
    n_cmp++;
    if ({bus.req1_ready, bus.busy} !== 2'b00) begin
      n_err++;
      $display("FAIL wr_after got ready/busy=%b want 00", {bus.req1_ready, bus.busy});
    end
  endtask

  task automatic test_long_wait();
    int nv, np;
    bit stable;
    nv = 0; np = 0; stable = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 24'h000040;
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.mem_ready = 1'b0;
      if (bus.mem_valid) begin
        nv++;
        if (bus.mem_addr !== 24'h000040 || bus.mem_write !== 1'b0) stable = 1'b0;
      end
      if (nv == 2) bus.req0_valid = 1'b0; // requester walks away mid-WAIT
      if (bus.req1_ready) np += 100;
      if (bus.req0_ready) begin
        np++;
        exp_rd0 = 32'h12345678;
        n_cmp++;
        if (bus.req0_rdata !== exp_rd0) begin
          n_err++;
          $display("FAIL long_rdata got=%h want=%h", bus.req0_rdata, exp_rd0);
        end
        $display("txn long: port=0 rdata=%h", bus.req0_rdata);
      end
      if (bus.mem_valid && nv == 11) begin
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12345678;
      end
    end
    n_cmp++;
    if (nv != 11) begin
      n_err++;
      $display("FAIL long_valid_cycles got=%0d want=11", nv);
    end
    n_cmp++;
    if (np != 1) begin
      n_err++;
      $display("FAIL long_pulses got=%0d want=1", np);
    end
    n_cmp++;
    if (!stable) begin
      n_err++;
      $display("FAIL long_stable mem fields changed during WAIT, want stable");
    end
  endtask

  task automatic test_timeout();
    int nv;
    bit got;
    nv = 0; got = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 24'h000200;
    bus.mem_ready = 1'b0;
`ifdef PSRAM_ARB_TIMEOUT_EN
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus.mem_valid) nv++;
      if (bus.req0_ready) begin
        got = 1'b1;
        bus.req0_valid = 1'b0;
        exp_rd0 = 32'hFFFF_FFFF;
        n_cmp++;
        if (bus.req0_rdata !== exp_rd0 || bus.err_timeout !== 1'b1) begin
          n_err++;
          $display("FAIL to_resp got rdata=%h err=%b want ffffffff 1", bus.req0_rdata, bus.err_timeout);
        end
        $display("txn timeout: port=0 rdata=%h", bus.req0_rdata);
      end
    end
    n_cmp++;
    if (nv != 8 || !got) begin
      n_err++;
      $display("FAIL to_wait_cycles got=%0d ready=%b want 8 1", nv, got);
    end
    tick(); tick();
    n_cmp++;
    if (bus.err_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL to_sticky got=%b want=1", bus.err_timeout);
    end
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    n_cmp++;
    if (bus.err_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL to_clear got=%b want=0", bus.err_timeout);
    end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.mem_valid) nv++;
      if (bus.req0_ready) got = 1'b1;
    end
    n_cmp++;
    if (nv != 20 || got || bus.err_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL nto_wait got valid=%0d ready=%b err=%b want 20 0 0", nv, got, bus.err_timeout);
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BADF00D;
    tick();
    bus.mem_ready = 1'b0;
    bus.req0_valid = 1'b0;
    exp_rd0 = 32'h0BADF00D;
    n_cmp++;
    if (bus.req0_ready !== 1'b1 || bus.req0_rdata !== exp_rd0) begin
      n_err++;
      $display("FAIL nto_resp got ready=%b rdata=%h want 1 %h", bus.req0_ready, bus.req0_rdata, exp_rd0);
    end
    $display("txn late: port=0 rdata=%h", bus.req0_rdata);
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
`endif
    tick();
  endtask

  task automatic test_spurious_ready();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    tick();
    bus.mem_ready = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.mem_valid, bus.req0_ready, bus.req1_ready} !== 4'b0) begin
      n_err++;
      $display("FAIL spur_state got=%b want 0000", {bus.busy, bus.mem_valid, bus.req0_ready, bus.req1_ready});
    end
    tick();
    n_cmp++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
        bus.req0_rdata !== exp_rd0 || bus.req1_rdata !== exp_rd1) begin
      n_err++;
      $display("FAIL spur_data got r0=%h r1=%h want %h %h", bus.req0_rdata, bus.req1_rdata, exp_rd0, exp_rd1);
    end
  endtask

  task automatic test_reset_in_wait();
    int np;
    np = 0;
    bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 24'h000300;
    tick(); // WAIT cycle 1
    tick(); // WAIT cycle 2
    n_cmp++;
    if (bus.mem_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre got mem_valid=%b want 1", bus.mem_valid);
    end
    #1 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_valid, bus.busy, bus.req0_ready, bus.req1_ready} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_async got=%b want 0000", {bus.mem_valid, bus.busy, bus.req0_ready, bus.req1_ready});
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77777777;
    tick();
    bus.mem_ready = 1'b0;
    bus.req0_valid = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.req0_ready || bus.req1_ready || bus.busy || bus.mem_valid) np++;
    end
    n_cmp++;
    if (np != 0 || bus.req0_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL rst_after got activity=%0d rdata0=%h want 0 0", np, bus.req0_rdata);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; auto_mem = 1'b0;
    exp_rd0 = '0; exp_rd1 = '0;
    bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0; bus.err_clear = 1'b0;
    test_reset();
    test_back_to_back();
    test_write_latency();
    test_long_wait();
    test_timeout();
    test_spurious_ready();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
